// File: rtl/reg_mux_pipe.sv
// Clock-enabled register chain with a runtime-selectable output tap.
// Latency changes drain the active stages so no sample is lost or duplicated.
module reg_mux_pipe #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             FLUSH,
  input  logic [LW-1:0]    LAT_SEL,
  input  logic             IN_VLD,
  input  logic [WIDTH-1:0] BLOCK_IN,
  output logic             IN_RDY,
  output logic             OUT_VLD,
  output logic [WIDTH-1:0] BLOCK_OUT,
  output logic             LAT_ERR
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t           state;
  state_t           state_nx;
  logic [LW-1:0]    lat_req;
  logic [LW-1:0]    lat_q;
  logic [LW-1:0]    lat_nx;
  logic             lat_oor;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] act_msk;
  logic             drained;
  logic             accept;

  // Clamp the requested latency to the physical depth.
  always_comb begin
    lat_oor = LAT_SEL > LW'(DEPTH);
    lat_req = lat_oor ? LW'(DEPTH) : LAT_SEL;
  end

  // Drain is complete once no valid sample sits at or below the active tap.
  always_comb begin
    act_msk = '0;
    for (int k = 0; k < DEPTH; k++)
      act_msk[k] = int'(lat_q) > k;
    drained = (v & act_msk) == '0;
  end

  // Next-state logic: leave RUN on any latency mismatch, adopt it once drained.
  always_comb begin
    state_nx = state;
    lat_nx   = lat_q;
    unique case (state)
      RUN: begin
        if (lat_req != lat_q)
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (drained) begin
          state_nx = RUN;
          lat_nx   = lat_req;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  // Handshake: only accept while running at the requested latency.
  always_comb begin
    IN_RDY = (state == RUN) && (lat_req == lat_q);
    accept = IN_VLD & IN_RDY;
  end

  // State and active-latency registers; reset adopts the request directly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      lat_q <= lat_req;
    end else begin
      state <= state_nx;
      lat_q <= lat_nx;
    end
  end

  // Stage data and valid shift; FLUSH drops valids but keeps data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++)
        d[k] <= '0;
    end else if (FLUSH) begin
      v <= '0;
    end else if (CE) begin
      d[0] <= BLOCK_IN;
      v[0] <= accept;
      for (int k = 1; k < DEPTH; k++) begin
        d[k] <= d[k-1];
        v[k] <= v[k-1];
      end
    end
  end

  // Sticky out-of-range latency flag.
  always_ff @(posedge CLK) begin
    if (RST)
      LAT_ERR <= 1'b0;
    else if (lat_oor)
      LAT_ERR <= 1'b1;
  end

  // Output tap: bypass at latency 0, otherwise the selected stage.
  always_comb begin
    BLOCK_OUT = BLOCK_IN;
    OUT_VLD   = accept;
    for (int k = 0; k < DEPTH; k++) begin
      if (lat_q == LW'(k + 1)) begin
        BLOCK_OUT = d[k];
        OUT_VLD   = v[k];
      end
    end
  end

endmodule

// File: doc/reg_mux_pipe.md
# reg_mux_pipe

Parametrised pipeline register bank for the DSP datapath: a chain of DEPTH clock-enabled registers with a runtime-selectable output tap (0 = combinational bypass) and per-stage valid tracking. Changing the latency is handled by a drain handshake, so no sample is lost or duplicated during the change. The block replaces fixed single-stage register/bypass pairs wherever the operand or product latency must be tuned per configuration, for example on the A/B/C/D/M/P operand paths.

## Interface
- WIDTH, 18, data width of BLOCK_IN/BLOCK_OUT
- DEPTH, 4, number of physical register stages (≥1)
- LW, $clog2(DEPTH+1), width of LAT_SEL (derived, not overridden)
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- CE  in  1  clock enable for data/valid shifting
- FLUSH  in  1  synchronous clear of all stage valid bits
- LAT_SEL  in  LW  requested latency in cycles (0..DEPTH)
- IN_VLD  in  1  input sample valid
- BLOCK_IN  in  WIDTH  input sample
- IN_RDY  out  1  input sample is accepted this cycle if IN_VLD & CE
- OUT_VLD  out  1  BLOCK_OUT carries a valid sample
- BLOCK_OUT  out  WIDTH  tapped output
- LAT_ERR  out  1  sticky flag: LAT_SEL was out of range

## Operation
- The effective request is `lat_req = min(LAT_SEL, DEPTH)`. `lat_q` (LW bits) holds the active latency.
- Stages 1..DEPTH each hold `d[k]` (WIDTH bits) and `v[k]`.
- Shift, when CE=1 and no RST or FLUSH:
  - `d[1] <= BLOCK_IN`, `v[1] <= IN_VLD & IN_RDY`.
  - `d[k] <= d[k-1]`, `v[k] <= v[k-1]`.
- CE=0: data and valid bits hold.
- Output when lat_q=0: BLOCK_OUT=BLOCK_IN and OUT_VLD=IN_VLD & IN_RDY (combinational).
- Output when lat_q>0: BLOCK_OUT=d[lat_q] and OUT_VLD=v[lat_q].
- FSM states are RUN and DRAIN. The FSM is evaluated every edge, independent of CE.
  - RUN → DRAIN when lat_req ≠ lat_q.
  - DRAIN → RUN when v[1..lat_q] are all 0 at the edge. On that edge, `lat_q <= lat_req` (the value sampled at that edge).
  - In DRAIN, if lat_req returns to lat_q, the FSM still completes the drain before returning to RUN.
- IN_RDY = (state==RUN) & (lat_req==lat_q). It is combinational, so no sample is accepted in the cycle LAT_SEL changes.
- In DRAIN, stage 1 loads bubbles (v[1]=0). Existing valid samples continue to shift out at the old tap while CE=1.
- Priority: RST > FLUSH > CE shift.
  - FLUSH clears every v[k] and keeps d[k].
  - FLUSH during DRAIN makes the drain condition true on the following edge.
- LAT_ERR is set on any edge where LAT_SEL > DEPTH and is cleared only by RST. It never affects the datapath beyond clamping.
- Samples are not realigned across a latency change. The drain guarantees every accepted sample exits at the latency in force when it was accepted.

## Timing
- Reset (RST=1 at an edge):
  - d[k]=0, v[k]=0, state=RUN, LAT_ERR=0, lat_q <= lat_req.
  - After that edge: OUT_VLD=0.
  - BLOCK_OUT is 0 if lat_q>0. If lat_q=0 it is BLOCK_IN (bypass).
  - IN_RDY=1 if LAT_SEL is stable.
- RST asserted mid-drain aborts the drain and adopts the current lat_req immediately.
- Latency is exactly lat_q enabled edges from input to output. CE=0 cycles stretch it in wall-clock time only.
- Latency change with an empty pipe: 1 edge to enter DRAIN, 1 edge to return to RUN. IN_RDY is low for 2 cycles.
- Latency change with a full pipe at CE=1: IN_RDY is low for 2 + (number of edges until the last valid at or below stage lat_q exits).
- The drain stalls indefinitely while CE=0 and a valid bit remains in stages 1..lat_q. FLUSH releases it.
- A simultaneous FLUSH and LAT_SEL change enters DRAIN and returns to RUN on the next edge.
- LAT_SEL=DEPTH uses the last stage. LAT_SEL in DEPTH+1..2^LW-1 behaves as DEPTH and sets LAT_ERR.

## Test plan
- Reset and fixed latency: RST 1 cycle, LAT_SEL=3, CE=1, IN_VLD=1, BLOCK_IN=1,2,3… → OUT_VLD rises on the 3rd edge after the first acceptance, BLOCK_OUT=1,2,3…; LAT_SEL=0 → BLOCK_OUT=BLOCK_IN in the same cycle.
- CE gating: lat 2, stream 10,11,12 with CE=0 for 2 cycles after 11 is accepted → outputs hold, sequence 10,11,12 exits with no gaps or duplicates once CE returns.
- Latency change on a full pipe: lat 4, stream 1..6, then LAT_SEL=1 → IN_RDY=0 until 1..6 have all exited at 4-cycle latency; next sample 7 appears 1 edge after acceptance.
- FLUSH: lat 3 with 3 samples in flight, FLUSH=1 for 1 cycle → OUT_VLD=0 for those samples; if asserted during a DRAIN, state returns to RUN on the next edge.
- Out of range: DEPTH=4, LAT_SEL=6 → latency 4, LAT_ERR=1 and stays 1 after LAT_SEL=2; cleared only by RST.
- Reset mid-drain: lat 4→1 change with valids in flight, RST at the 2nd DRAIN cycle → all v=0, lat_q=1, IN_RDY=1 after the RST edge.
